music_player_ctrl: RTL and testbench
====================================

# music_player_ctrl

Sequencer and arbiter for the single-port music sample ROM (`music`, 54832 × 17-bit, 1-cycle registered read).
- Generates the ROM address stream at a fixed sample rate.
- Shares the ROM between a looping background track and a one-shot shuttle-hit effect clip; the effect has priority and pre-empts the track.
- Delivers one sample per tick to the audio output stage with a valid strobe.

## Interface
Parameters:
- `ADDR_W`, 17: ROM address width.
- `DATA_W`, 17: ROM sample width.
- `SAMPLE_DIV`, 1134: Clk cycles per sample (50 MHz / 44.1 kHz). Legal minimum is 4.
- `BG_LEN`, 49152: background track length. The track occupies addresses 0..BG_LEN-1.
- `EFX_BASE`, 49152: first address of the effect clip.
- `EFX_LEN`, 5680: effect clip length. EFX_BASE+EFX_LEN ≤ 54832.

Ports:
- `Clk` in 1: system clock. There is one clock.
- `Reset` in 1: synchronous, active-high reset.
- `play` in 1: level-sampled start request for the background track.
- `stop` in 1: halts all playback and returns to IDLE.
- `loop_en` in 1: when high, the background track wraps to 0 at its end.
- `efx_trig` in 1: single-cycle pulse that starts the effect clip.
- `Add` out ADDR_W: address to the ROM.
- `music_content` in DATA_W: ROM data. It is valid one cycle after `Add`.
- `sample_out` out DATA_W: current sample, held until the next valid.
- `sample_valid` out 1: one-cycle strobe when `sample_out` updates.
- `busy` out 1: high in BG or EFX state.
- `efx_active` out 1: high in EFX state.

## Operation
- States are IDLE, BG and EFX.
- Registers: `bg_ptr` and `efx_ptr`, both ADDR_W; tick divider `div_cnt`, 0..SAMPLE_DIV-1.
- `div_cnt` runs freely from reset. `tick` is high in the cycle where `div_cnt == SAMPLE_DIV-1`.
- State actions and transitions are evaluated every cycle. Priority is `stop` > `efx_trig` > `play`.
- **stop**: any state goes to IDLE. `bg_ptr` and `efx_ptr` clear to 0. Any sample already in the pipeline is discarded (no `sample_valid`).
- **efx_trig**:
  - From IDLE or BG: go to EFX, with `efx_ptr` = EFX_BASE. `bg_ptr` is frozen.
  - In EFX: restart the clip, with `efx_ptr` = EFX_BASE.
- **play**: IDLE → BG with `bg_ptr` = 0. Ignored in BG and EFX.
- **BG, on tick**:
  - Issue `Add` = `bg_ptr`.
  - If `bg_ptr` == BG_LEN-1: with `loop_en` high, `bg_ptr` goes to 0; otherwise go to IDLE after issuing the last address.
  - Otherwise `bg_ptr` increments.
- **EFX, on tick**:
  - Issue `Add` = `efx_ptr`, then increment.
  - After issuing EFX_BASE+EFX_LEN-1, return to BG if the track was active at trigger time, else to IDLE.
  - `bg_ptr` resumes from its frozen value.
- **IDLE**: no address is issued on tick. `Add` holds its last value. `sample_out` holds its last value.
- Pointers never exceed their region. There is no arithmetic overflow at ADDR_W because all bounds are < 2^17.

## Timing
- Tick in cycle t:
  - `Add` is registered at the end of t.
  - The ROM registers its data at the end of t+1.
  - `sample_out` is registered at the end of t+2.
  - `sample_valid` is high in cycle t+3 only.
- Fixed latency is 3 cycles from tick to valid. This needs SAMPLE_DIV ≥ 4, so at most one sample is in flight.
- Reset values: `Add`=0, `sample_out`=0, `sample_valid`=0, `busy`=0, `efx_active`=0, `div_cnt`=0, state IDLE.
- `Reset` mid-playback takes effect next edge. In-flight samples are dropped.
- `efx_trig` and a tick in the same cycle: the state change applies first. That tick issues EFX_BASE, and the frozen `bg_ptr` is not advanced.
- `stop` and `efx_trig` in the same cycle: `stop` wins, giving IDLE.
- `play` and `efx_trig` in the same cycle from IDLE: go to EFX, with "track active" recorded. After the clip ends, go to BG at `bg_ptr` = 0.
- `busy` and `efx_active` are registered from state and change the cycle after the transition.

## Structure
- Shared package `music_pkg`:
  - `ADDR_W`, `DATA_W`
  - `MUSIC_DEPTH` = 54832
  - enum `music_state_t` {IDLE, BG, EFX}
  - default `SAMPLE_DIV`
- Sub-module `sample_tick_gen`: parameterised divider with a `tick` output and synchronous reset.
- The FSM, pointer logic and 3-stage valid pipeline stay in `music_player_ctrl`. The `music` ROM is instantiated by the parent, not inside this block.

## Test plan
Bench parameters: SAMPLE_DIV=4, BG_LEN=8, EFX_BASE=8, EFX_LEN=3. The ROM model returns data = address + 0x100.

1. `play` pulse with `loop_en`=0 → `Add` sequence 0..7 one per 4 cycles. `sample_out` values 0x100..0x107, each `sample_valid` 3 cycles after its tick. Then IDLE, `busy`=0.
2. `loop_en`=1, run 20 ticks → addresses 0..7,0..7,0..3. No gap at the wrap.
3. `efx_trig` after BG issues address 3 → next addresses 8,9,10, then 4,5… `efx_active` is high for exactly those 3 ticks.
4. Second `efx_trig` while EFX is at address 9 → sequence 8,9,8,9,10, then resumes BG.
5. `stop` and `efx_trig` in the same cycle during BG → IDLE. No further `sample_valid`. Pointers are 0, and a following `play` restarts at 0.
6. `Reset` asserted 1 cycle after a tick → no `sample_valid`. All outputs are 0 the next cycle.

Source files
------------

// File: rtl/music_pkg.sv
// Shared constants and state type for the music sample ROM sequencer.
// Defaults describe the full-size ROM at 50 MHz core clock / 44.1 kHz sample rate.
package music_pkg;

   localparam int ADDR_W         = 17;
   localparam int DATA_W         = 17;
   localparam int MUSIC_DEPTH    = 54832;
   localparam int SAMPLE_DIV_DEF = 1134;
   localparam int BG_LEN_DEF     = 49152;
   localparam int EFX_BASE_DEF   = 49152;
   localparam int EFX_LEN_DEF    = 5680;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BG   = 2'd1,
      EFX  = 2'd2
   } music_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider; tick is high for one cycle every DIV cycles.
// Combinational tick from the count register, no backpressure.
module sample_tick_gen #(
   parameter int DIV = music_pkg::SAMPLE_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int              CNT_W   = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] div_cnt_q;
   logic [CNT_W-1:0] div_cnt_d;

   always_comb begin
      tick      = (div_cnt_q == CNT_MAX);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/music_player_ctrl.sv
// Sequences background track and pre-empting effect clip through the shared sample ROM.
// Tick to sample_valid is 3 cycles; no backpressure, stop/Reset drop the sample in flight.
module music_player_ctrl
   import music_pkg::*;
#(
   parameter int ADDR_W     = music_pkg::ADDR_W,
   parameter int DATA_W     = music_pkg::DATA_W,
   parameter int SAMPLE_DIV = music_pkg::SAMPLE_DIV_DEF,
   parameter int BG_LEN     = music_pkg::BG_LEN_DEF,
   parameter int EFX_BASE   = music_pkg::EFX_BASE_DEF,
   parameter int EFX_LEN    = music_pkg::EFX_LEN_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              play,
   input  logic              stop,
   input  logic              loop_en,
   input  logic              efx_trig,
   output logic [ADDR_W-1:0] Add,
   input  logic [DATA_W-1:0] music_content,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   output logic              busy,
   output logic              efx_active
);

   localparam logic [ADDR_W-1:0] BG_LAST   = ADDR_W'(BG_LEN - 1);
   localparam logic [ADDR_W-1:0] EFX_FIRST = ADDR_W'(EFX_BASE);
   localparam logic [ADDR_W-1:0] EFX_LAST  = ADDR_W'(EFX_BASE + EFX_LEN - 1);

   logic tick;

   music_state_t      state_q,   state_d;
   logic [ADDR_W-1:0] bg_ptr_q,  bg_ptr_d;
   logic [ADDR_W-1:0] efx_ptr_q, efx_ptr_d;
   logic              trk_act_q, trk_act_d;
   logic [ADDR_W-1:0] add_q,     add_d;
   logic              p1_q,      p1_d;
   logic              p2_q,      p2_d;
   logic [DATA_W-1:0] smp_q,     smp_d;
   logic              smp_vld_q, smp_vld_d;
   logic              busy_q,    busy_d;
   logic              efx_act_q, efx_act_d;

   sample_tick_gen #(
      .DIV (SAMPLE_DIV)
   ) u_tick (
      .clk   (Clk),
      .reset (Reset),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      bg_ptr_d  = bg_ptr_q;
      efx_ptr_d = efx_ptr_q;
      trk_act_d = trk_act_q;
      add_d     = add_q;
      p1_d      = 1'b0;
      p2_d      = p1_q;
      smp_vld_d = p2_q;
      smp_d     = p2_q ? music_content : smp_q;

      if (stop) begin
         state_d   = IDLE;
         bg_ptr_d  = '0;
         efx_ptr_d = '0;
         trk_act_d = 1'b0;
         p2_d      = 1'b0;
         smp_vld_d = 1'b0;
         smp_d     = smp_q;
      end else begin
         // Commands resolve first so a coincident tick already acts in the new state.
         if (efx_trig) begin
            if (state_q != EFX) begin
               trk_act_d = (state_q == BG) || play;
            end
            if ((state_q == IDLE) && play) begin
               bg_ptr_d = '0;
            end
            state_d   = EFX;
            efx_ptr_d = EFX_FIRST;
         end else if (play && (state_q == IDLE)) begin
            state_d  = BG;
            bg_ptr_d = '0;
         end

         if (tick) begin
            case (state_d)
               BG: begin
                  add_d = bg_ptr_d;
                  p1_d  = 1'b1;
                  if (bg_ptr_d == BG_LAST) begin
                     bg_ptr_d = '0;
                     if (!loop_en) begin
                        state_d = IDLE;
                     end
                  end else begin
                     bg_ptr_d = bg_ptr_d + 1'b1;
                  end
               end
               EFX: begin
                  add_d = efx_ptr_d;
                  p1_d  = 1'b1;
                  if (efx_ptr_d == EFX_LAST) begin
                     efx_ptr_d = '0;
                     state_d   = trk_act_d ? BG : IDLE;
                  end else begin
                     efx_ptr_d = efx_ptr_d + 1'b1;
                  end
               end
               IDLE:    ;
               default: ;
            endcase
         end
      end

      busy_d    = (state_d != IDLE);
      efx_act_d = (state_d == EFX);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         bg_ptr_q  <= '0;
         efx_ptr_q <= '0;
         trk_act_q <= 1'b0;
         add_q     <= '0;
         p1_q      <= 1'b0;
         p2_q      <= 1'b0;
         smp_q     <= '0;
         smp_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         efx_act_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bg_ptr_q  <= bg_ptr_d;
         efx_ptr_q <= efx_ptr_d;
         trk_act_q <= trk_act_d;
         add_q     <= add_d;
         p1_q      <= p1_d;
         p2_q      <= p2_d;
         smp_q     <= smp_d;
         smp_vld_q <= smp_vld_d;
         busy_q    <= busy_d;
         efx_act_q <= efx_act_d;
      end
   end

   assign Add          = add_q;
   assign sample_out   = smp_q;
   assign sample_valid = smp_vld_q;
   assign busy         = busy_q;
   assign efx_active   = efx_act_q;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Bench for music_player_ctrl with a small ROM model (data = address + 0x100).
module tb_music_player_ctrl;

   localparam int AW  = 17;
   localparam int DW  = 17;
   localparam int DIV = 4;
   localparam int BGL = 8;
   localparam int EB  = 8;
   localparam int EL  = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          play;
   logic          stop;
   logic          loop_en;
   logic          efx_trig;
   logic [AW-1:0] Add;
   logic [DW-1:0] music_content;
   logic [DW-1:0] sample_out;
   logic          sample_valid;
   logic          busy;
   logic          efx_active;

   int vectors     = 0;
   int miscompares = 0;
   int cyc;

   int obs_val[$], obs_cyc[$], obs_add[$];
   bit obs_busy[$], obs_efx[$];
   int exp_val[$], exp_cyc[$], exp_add[$];
   bit exp_busy[$], exp_efx[$];

   // reference model: mode 0 idle, 1 track, 2 effect
   int m_mode, m_bg, m_efx, m_add, m_last;
   bit m_resume, m_emit;

   always #5 Clk = ~Clk;

   always_ff @(posedge Clk) music_content <= Add + 17'h100;

   music_player_ctrl #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .SAMPLE_DIV (DIV),
      .BG_LEN     (BGL),
      .EFX_BASE   (EB),
      .EFX_LEN    (EL)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .play          (play),
      .stop          (stop),
      .loop_en       (loop_en),
      .efx_trig      (efx_trig),
      .Add           (Add),
      .music_content (music_content),
      .sample_out    (sample_out),
      .sample_valid  (sample_valid),
      .busy          (busy),
      .efx_active    (efx_active)
   );

   task automatic model_reset();
      m_mode = 0; m_bg = 0; m_efx = 0; m_add = 0; m_last = -1;
      m_resume = 0; m_emit = 0;
      obs_val.delete(); obs_cyc.delete(); obs_add.delete(); obs_busy.delete(); obs_efx.delete();
      exp_val.delete(); exp_cyc.delete(); exp_add.delete(); exp_busy.delete(); exp_efx.delete();
      cyc = 0;
   endtask

   task automatic model_cycle(input bit p, input bit s, input bit e, input bit l);
      m_emit = 0;
      if (s) begin
         m_mode = 0; m_bg = 0; m_efx = 0; m_resume = 0;
         while (exp_cyc.size() > 0 && exp_cyc[$] > cyc) begin
            void'(exp_cyc.pop_back());
            void'(exp_val.pop_back());
         end
      end else begin
         if (e) begin
            if (m_mode != 2) m_resume = (m_mode == 1) || p;
            if (m_mode == 0 && p) m_bg = 0;
            m_mode = 2;
            m_efx  = 0;
         end else if (p && m_mode == 0) begin
            m_mode = 1;
            m_bg   = 0;
         end
         if ((cyc % DIV) == DIV - 1 && m_mode != 0) begin
            m_emit = 1;
            if (m_mode == 1) begin
               m_last = m_bg;
               if (m_bg + 1 < BGL) m_bg = m_bg + 1;
               else begin
                  m_bg = 0;
                  if (!l) m_mode = 0;
               end
            end else begin
               m_last = EB + m_efx;
               m_efx  = m_efx + 1;
               if (m_efx == EL) begin
                  m_efx  = 0;
                  m_mode = m_resume ? 1 : 0;
               end
            end
            m_add = m_last;
            exp_val.push_back(m_last + 'h100);
            exp_cyc.push_back(cyc + 3);
         end
      end
      exp_add.push_back(m_add);
      exp_busy.push_back(m_mode != 0);
      exp_efx.push_back(m_mode == 2);
   endtask

   task automatic step(input bit p, input bit s, input bit e, input bit l);
      play = p; stop = s; efx_trig = e; loop_en = l;
      @(posedge Clk);
      model_cycle(p, s, e, l);
      cyc++;
      #1;
      if (sample_valid) begin
         obs_val.push_back(int'(sample_out));
         obs_cyc.push_back(cyc);
      end
      obs_add.push_back(int'(Add));
      obs_busy.push_back(busy);
      obs_efx.push_back(efx_active);
   endtask

   task automatic apply_reset();
      Reset = 1'b1; play = 1'b0; stop = 1'b0; loop_en = 1'b0; efx_trig = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      model_reset();
   endtask

   task automatic wait_emit(input int addr, input bit l, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         step(0, 0, 0, l);
         if (m_emit && m_last == addr) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++; if (Add !== '0)        begin miscompares++; $display("FAIL reset_add got %0h want 0", Add); end
      vectors++; if (sample_out !== '0) begin miscompares++; $display("FAIL reset_sample got %0h want 0", sample_out); end
      vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", sample_valid); end
      vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (efx_active !== 1'b0) begin miscompares++; $display("FAIL reset_efx got %b want 0", efx_active); end
   endtask

   task automatic test_play_once();
      apply_reset();
      step(1, 0, 0, 0);
      repeat (39) step(0, 0, 0, 0);
      vectors++;
      if (obs_val.size() != BGL) begin
         miscompares++; $display("FAIL play_once_count got %0d want %0d", obs_val.size(), BGL);
      end
      for (int i = 0; i < BGL && i < obs_val.size(); i++) begin
         vectors++;
         if (obs_val[i] !== 'h100 + i || obs_cyc[i] !== 4 * i + 6) begin
            miscompares++;
            $display("FAIL play_once[%0d] got %0h@%0d want %0h@%0d", i, obs_val[i], obs_cyc[i], 'h100 + i, 4 * i + 6);
         end
      end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL play_once_busy got %b want 0", busy); end
   endtask

   task automatic test_loop();
      apply_reset();
      step(1, 0, 0, 1);
      repeat (89) step(0, 0, 0, 1);
      vectors++;
      if (obs_val.size() < 20) begin
         miscompares++; $display("FAIL loop_count got %0d want >=20", obs_val.size());
      end
      for (int i = 0; i < 20 && i < obs_val.size(); i++) begin
         vectors++;
         if (obs_val[i] !== 'h100 + (i % BGL) || obs_cyc[i] !== 4 * i + 6) begin
            miscompares++;
            $display("FAIL loop[%0d] got %0h@%0d want %0h@%0d", i, obs_val[i], obs_cyc[i], 'h100 + (i % BGL), 4 * i + 6);
         end
      end
   endtask

   task automatic test_efx_preempt();
      int tab[9] = '{0, 1, 2, 3, 8, 9, 10, 4, 5};
      int ecnt = 0;
      bit ok;
      apply_reset();
      step(1, 0, 0, 1);
      wait_emit(3, 1, 40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL preempt_wait got timeout want addr 3"); end
      step(0, 0, 1, 1);
      repeat (30) begin
         step(0, 0, 0, 1);
         if ((cyc % DIV) == DIV - 1 && efx_active) ecnt++;
      end
      vectors++; if (ecnt != EL) begin miscompares++; $display("FAIL preempt_efx_ticks got %0d want %0d", ecnt, EL); end
      for (int i = 0; i < 9; i++) begin
         vectors++;
         if (i >= obs_val.size() || obs_val[i] !== 'h100 + tab[i]) begin
            miscompares++;
            $display("FAIL preempt[%0d] got %0h want %0h", i, (i < obs_val.size()) ? obs_val[i] : -1, 'h100 + tab[i]);
         end
      end
   endtask

   task automatic test_efx_retrigger();
      int tab[11] = '{0, 1, 2, 3, 8, 9, 8, 9, 10, 4, 5};
      bit ok;
      apply_reset();
      step(1, 0, 0, 1);
      wait_emit(3, 1, 40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL retrig_wait3 got timeout want addr 3"); end
      step(0, 0, 1, 1);
      wait_emit(9, 1, 20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL retrig_wait9 got timeout want addr 9"); end
      step(0, 0, 1, 1);
      repeat (30) step(0, 0, 0, 1);
      for (int i = 0; i < 11; i++) begin
         vectors++;
         if (i >= obs_val.size() || obs_val[i] !== 'h100 + tab[i]) begin
            miscompares++;
            $display("FAIL retrig[%0d] got %0h want %0h", i, (i < obs_val.size()) ? obs_val[i] : -1, 'h100 + tab[i]);
         end
      end
   endtask

   task automatic test_stop_efx();
      bit ok;
      apply_reset();
      step(1, 0, 0, 1);
      wait_emit(2, 1, 40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL stop_wait got timeout want addr 2"); end
      step(0, 1, 1, 1);
      repeat (16) step(0, 0, 0, 1);
      vectors++; if (obs_val.size() != 2) begin miscompares++; $display("FAIL stop_drop got %0d samples want 2", obs_val.size()); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy got %b want 0", busy); end
      vectors++; if (efx_active !== 1'b0) begin miscompares++; $display("FAIL stop_efx got %b want 0", efx_active); end
      step(1, 0, 0, 1);
      repeat (11) step(0, 0, 0, 1);
      vectors++;
      if (obs_val.size() < 3 || obs_val[2] !== 'h100) begin
         miscompares++;
         $display("FAIL stop_restart got %0h want 100", (obs_val.size() >= 3) ? obs_val[2] : -1);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      apply_reset();
      step(1, 0, 0, 0);
      wait_emit(2, 0, 40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_wait got timeout want addr 2"); end
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      vectors++; if (Add !== '0)        begin miscompares++; $display("FAIL rstmid_add got %0h want 0", Add); end
      vectors++; if (sample_out !== '0) begin miscompares++; $display("FAIL rstmid_sample got %0h want 0", sample_out); end
      vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", sample_valid); end
      vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
      vectors++; if (efx_active !== 1'b0) begin miscompares++; $display("FAIL rstmid_efx got %b want 0", efx_active); end
      Reset = 1'b0;
      model_reset();
      repeat (12) step(0, 0, 0, 0);
      vectors++; if (obs_val.size() != 0) begin miscompares++; $display("FAIL rstmid_drop got %0d samples want 0", obs_val.size()); end
   endtask

   task automatic test_random();
      bit lv = 1'b1;
      int n_exp = 0;
      apply_reset();
      repeat (1200) begin
         bit p, s, e;
         p = ($urandom_range(0, 19) == 0);
         s = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) lv = ~lv;
         step(p, s, e, lv);
      end
      foreach (exp_cyc[i]) if (exp_cyc[i] <= cyc) n_exp++;
      vectors++;
      if (obs_val.size() != n_exp) begin
         miscompares++; $display("FAIL rand_count got %0d want %0d", obs_val.size(), n_exp);
      end
      for (int i = 0; i < n_exp && i < obs_val.size(); i++) begin
         vectors++;
         if (obs_val[i] !== exp_val[i] || obs_cyc[i] !== exp_cyc[i]) begin
            miscompares++;
            $display("FAIL rand_sample[%0d] got %0h@%0d want %0h@%0d", i, obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
         end
      end
      for (int i = 0; i < exp_add.size(); i++) begin
         vectors++;
         if (obs_add[i] !== exp_add[i] || obs_busy[i] !== exp_busy[i] || obs_efx[i] !== exp_efx[i]) begin
            miscompares++;
            $display("FAIL rand_cycle[%0d] got add=%0h busy=%b efx=%b want add=%0h busy=%b efx=%b",
                     i + 1, obs_add[i], obs_busy[i], obs_efx[i], exp_add[i], exp_busy[i], exp_efx[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_play_once();
      test_loop();
      test_efx_preempt();
      test_efx_retrigger();
      test_stop_efx();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
